scan_controller: RTL

SCAN_CONTROLLER -- requirements
Module: scan_controller

---
 rtl/scan_controller_pkg.sv | 23 ++
 rtl/scan_controller_addr_counter.sv | 35 +++
 rtl/scan_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/scan_controller_pkg.sv
// Shared definitions for the scan controller: FSM state encodings and default widths.
// Latency: none (definitions only).
// Backpressure: not applicable.
package scan_controller_pkg;

    // Default counter and pass-count widths
    localparam int N_DEFAULT = 6;
    localparam int P_DEFAULT = 4;

    // State encodings, kept explicit so waveforms and debug taps stay stable
    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_LOAD = 2'd1;
    localparam logic [1:0] ENC_RUN  = 2'd2;
    localparam logic [1:0] ENC_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        LOAD = ENC_LOAD,
        RUN  = ENC_RUN,
        DONE = ENC_DONE
    } state_t;

endpackage

// File: rtl/scan_controller_addr_counter.sv
// Loadable N-bit up-counter that saturates at all-ones and flags the carry-out.
// Latency: load and increment both take effect at the next rising edge.
// Backpressure: en=0 holds the count; co only asserts while enabled.
module addr_counter
    import scan_controller_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         ld,
    input  logic [N-1:0] initld,
    output logic         co,
    output logic [N-1:0] out
);

    logic all_ones;

    assign all_ones = &out;
    // Carry-out marks the last address of a pass being consumed this cycle
    assign co       = en & all_ones;

    // Count register: load wins, otherwise step; never wraps past all-ones within a pass
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else if (ld) begin
            out <= initld;
        end else if (en && !all_ones) begin
            out <= out + 1'b1;
        end
    end

endmodule

// File: rtl/scan_controller.sv
// Multi-pass address scanner: sweeps init_addr..all-ones once per pass, num_passes times.
// Latency: start at edge k -> LOAD in cycle k+1, first valid address in cycle k+2; one bubble between passes.
// Backpressure: stall=1 holds the current address (and delays end of pass); start ignored while busy.
module scan_controller
    import scan_controller_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int P = P_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] init_addr,
    input  logic [P-1:0] num_passes,
    input  logic         stall,
    output logic [N-1:0] addr,
    output logic         addr_valid,
    output logic [P-1:0] pass_idx,
    output logic         busy,
    output logic         done
);

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] init_q;
    logic [P-1:0] passes_q;
    logic         cnt_en;
    logic         cnt_ld;
    logic         cnt_co;
    logic         accept;
    logic         pass_end;
    logic         last_pass;

    // Counter controls depend only on registered state and stall, so the carry-out
    // can feed the next-state logic without a combinational loop
    assign cnt_en    = (state == RUN) && !stall;
    assign cnt_ld    = (state == LOAD);
    assign last_pass = (P'(pass_idx + 1'b1) == passes_q);

    addr_counter #(
        .N (N)
    ) u_addr_counter (
        .clk    (clk),
        .rst    (rst),
        .en     (cnt_en),
        .ld     (cnt_ld),
        .initld (init_q),
        .co     (cnt_co),
        .out    (addr)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state outputs
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        pass_end   = 1'b0;
        addr_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (num_passes == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                addr_valid = 1'b1;
                if (cnt_co) begin
                    pass_end  = 1'b1;
                    state_nxt = last_pass ? DONE : LOAD;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Scan parameters are frozen at start acceptance so mid-scan input changes are harmless
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q   <= '0;
            passes_q <= '0;
        end else if (accept) begin
            init_q   <= init_addr;
            passes_q <= num_passes;
        end
    end

    // Pass index: cleared on acceptance, bumped once per completed pass
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_idx <= '0;
        end else if (accept) begin
            pass_idx <= '0;
        end else if (pass_end) begin
            pass_idx <= pass_idx + 1'b1;
        end
    end

endmodule
